// File: rtl/miriscv_data_bus_ctrl.sv
// miriscv_data_bus_ctrl: sequences one core load/store at a time onto either
// the on-chip RAM data port or one of two APB slaves (UART, timer). It runs a
// two-phase APB transfer with a wait-state timeout and returns one registered
// rvalid/rdata response per request.
module miriscv_data_bus_ctrl #(
  parameter int XLEN        = 32,
  parameter int APB_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  // Core side
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [XLEN/8-1:0] core_be_i,
  input  logic [XLEN-1:0]   core_addr_i,
  input  logic [XLEN-1:0]   core_wdata_i,
  output logic              core_rvalid_o,
  output logic [XLEN-1:0]   core_rdata_o,
  output logic              bus_err_o,
  // RAM data port
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [XLEN/8-1:0] ram_be_o,
  output logic [XLEN-1:0]   ram_addr_o,
  output logic [XLEN-1:0]   ram_wdata_o,
  input  logic [XLEN-1:0]   ram_rdata_i,
  // Shared APB master
  output logic              uart_psel_o,
  output logic              timer_psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [XLEN-1:0]   paddr_o,
  output logic [XLEN-1:0]   pwdata_o,
  output logic [XLEN/8-1:0] pstrb_o,
  input  logic [XLEN-1:0]   uart_prdata_i,
  input  logic              uart_pready_i,
  input  logic [XLEN-1:0]   timer_prdata_i,
  input  logic              timer_pready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_REQ,
    S_RAM_WAIT,
    S_APB_SETUP,
    S_APB_ACCESS,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_UART,
    TGT_TIMER
  } target_e;

  // Last wait-state count before the transfer is abandoned.
  localparam logic [15:0]     CNT_LAST = 16'(APB_TIMEOUT - 1);
  localparam logic [XLEN-1:0] ERR_DATA = XLEN'(32'hDEAD_BEEF);

  state_e              state_q;
  target_e             tgt_q;
  target_e             req_tgt;
  logic [XLEN-1:0]     addr_q;
  logic                we_q;
  logic [XLEN/8-1:0]   be_q;
  logic [XLEN-1:0]     wdata_q;
  logic [15:0]         cnt_q;
  logic                err_q;
  logic [XLEN-1:0]     resp_q;
  logic                rvalid_q;
  logic                ram_req_q;
  logic                uart_psel_q;
  logic                timer_psel_q;
  logic                penable_q;
  logic                sel_pready;
  logic [XLEN-1:0]     sel_prdata;

  // Address decode of the incoming request, used only when IDLE latches it.
  always_comb begin
    // NOTE: default first so every path assigns req_tgt and no latch is inferred.
    req_tgt = TGT_RAM;
    if (core_addr_i[XLEN-1]) begin
      req_tgt = core_addr_i[12] ? TGT_TIMER : TGT_UART;
    end
  end

  // Ready/data of the slave chosen by the latched target.
  assign sel_pready = (tgt_q == TGT_TIMER) ? timer_pready_i : uart_pready_i;
  assign sel_prdata = (tgt_q == TGT_TIMER) ? timer_prdata_i : uart_prdata_i;

  // Transfer FSM with registered strobes, request latch and response register.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    // NOTE: the request and response data registers are reset as well, so that
    // every downstream output reads 0 straight out of reset.
    if (!arstn_i) begin
      state_q      <= S_IDLE;
      tgt_q        <= TGT_RAM;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      resp_q       <= '0;
      rvalid_q     <= 1'b0;
      ram_req_q    <= 1'b0;
      uart_psel_q  <= 1'b0;
      timer_psel_q <= 1'b0;
      penable_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge, independent of statement order.
      case (state_q)
        S_IDLE: begin
          if (core_req_i) begin
            tgt_q   <= req_tgt;
            addr_q  <= core_addr_i;
            we_q    <= core_we_i;
            be_q    <= core_be_i;
            wdata_q <= core_wdata_i;
            if (req_tgt == TGT_RAM) begin
              ram_req_q <= 1'b1;
              state_q   <= S_RAM_REQ;
            end else begin
              uart_psel_q  <= (req_tgt == TGT_UART);
              timer_psel_q <= (req_tgt == TGT_TIMER);
              state_q      <= S_APB_SETUP;
            end
          end
        end
        S_RAM_REQ: begin
          ram_req_q <= 1'b0;
          state_q   <= S_RAM_WAIT;
        end
        S_RAM_WAIT: begin
          resp_q   <= we_q ? '0 : ram_rdata_i;
          rvalid_q <= 1'b1;
          state_q  <= S_RESP;
        end
        S_APB_SETUP: begin
          cnt_q     <= '0;
          penable_q <= 1'b1;
          state_q   <= S_APB_ACCESS;
        end
        S_APB_ACCESS: begin
          if (sel_pready || cnt_q == CNT_LAST) begin
            // Either completion or timeout closes the APB transfer.
            resp_q       <= sel_pready ? (we_q ? '0 : sel_prdata) : ERR_DATA;
            err_q        <= !sel_pready;
            uart_psel_q  <= 1'b0;
            timer_psel_q <= 1'b0;
            penable_q    <= 1'b0;
            rvalid_q     <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RESP: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = resp_q;
  assign bus_err_o     = err_q;

  assign ram_req_o     = ram_req_q;
  assign ram_we_o      = we_q;
  assign ram_be_o      = be_q;
  assign ram_addr_o    = addr_q;
  assign ram_wdata_o   = wdata_q;

  assign uart_psel_o   = uart_psel_q;
  assign timer_psel_o  = timer_psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = we_q;
  assign paddr_o       = addr_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = be_q;

endmodule

// File: tb/tb_miriscv_data_bus_ctrl.sv
// Bench for miriscv_data_bus_ctrl: directed requests push their expected
// response into a scoreboard; a negedge monitor checks every rvalid against it.
module tb_miriscv_data_bus_ctrl;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        core_req_i, core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_rvalid_o, bus_err_o;
  logic [31:0] core_rdata_o;
  logic        ram_req_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic        uart_psel_o, timer_psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] uart_prdata_i, timer_prdata_i;
  logic        uart_pready_i, timer_pready_i;

  miriscv_data_bus_ctrl #(.XLEN(32), .APB_TIMEOUT(8)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .bus_err_o(bus_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .uart_psel_o(uart_psel_o), .timer_psel_o(timer_psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .uart_prdata_i(uart_prdata_i), .uart_pready_i(uart_pready_i),
    .timer_prdata_i(timer_prdata_i), .timer_pready_i(timer_pready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        overlap = 1'b0;

  // Per-cycle observations of the last request, indexed by cycle offset.
  logic        obs_ram [0:31];
  logic        obs_up  [0:31];
  logic        obs_tp  [0:31];
  logic        obs_pen [0:31];
  logic [31:0] obs_paddr [0:31];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each response strobe against the scoreboard head.
  always @(negedge clk_i) begin
    if (ram_req_o && (uart_psel_o || timer_psel_o)) overlap <= 1'b1;
    if (uart_psel_o && timer_psel_o) overlap <= 1'b1;
    if (bus_err_o && !core_rvalid_o) check("bus_err_without_rvalid", bus_err_o, 1'b0);
    if (core_rvalid_o) begin
      if (sb.size() == 0) begin
        check("spurious_rvalid", core_rvalid_o, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("rdata", core_rdata_o, mon_e.rdata);
        check("bus_err", bus_err_o, mon_e.err);
        check("rvalid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Issue one request, drive the selected pready on a schedule (high in SETUP
  // to prove it is ignored, then high from cycle offset rdy_at) and record
  // per-cycle bus activity until the response strobe is seen.
  task automatic run_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat,
                         input logic [31:0] exp_rdata, input logic exp_err, input int rdy_at);
    int   c0;
    int   k;
    logic rdy;
    logic is_timer;
    bit   done;
    exp_t e;
    done = 0;
    is_timer = addr[31] & addr[12];
    for (int i = 0; i < 32; i++) begin
      obs_ram[i] = 0; obs_up[i] = 0; obs_tp[i] = 0; obs_pen[i] = 0; obs_paddr[i] = 0;
    end
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = we; core_be_i = be;
    core_addr_i = addr; core_wdata_i = wdata;
    c0 = cyc;
    e.rdata = exp_rdata; e.err = exp_err; e.cyc = c0 + lat;
    sb.push_back(e);
    for (int n = 0; n < 40 && !done; n++) begin
      k = cyc - c0;
      if (k < 32) begin
        obs_ram[k] = ram_req_o; obs_up[k] = uart_psel_o; obs_tp[k] = timer_psel_o;
        obs_pen[k] = penable_o; obs_paddr[k] = paddr_o;
      end
      if (core_rvalid_o) begin
        done = 1;
      end else begin
        rdy = (k == 1) || (k >= rdy_at);
        uart_pready_i  = is_timer ? 1'b1 : rdy;
        timer_pready_i = is_timer ? rdy : 1'b1;
        @(negedge clk_i);
      end
    end
    if (!done) check("response_within_budget", core_rvalid_o, 1'b1);
    core_req_i = 1'b0;
    uart_pready_i = 1'b0;
    timer_pready_i = 1'b0;
  endtask

  initial begin
    arstn_i = 1'b0;
    core_req_i = 0; core_we_i = 0; core_be_i = 0; core_addr_i = 0; core_wdata_i = 0;
    ram_rdata_i = 32'h1234_5678;
    uart_prdata_i = 32'h0BAD_0BAD;
    timer_prdata_i = 32'h0000_00FF;
    uart_pready_i = 0; timer_pready_i = 0;

    repeat (3) @(negedge clk_i);
    check("reset_outputs_zero", |{core_rvalid_o, core_rdata_o, bus_err_o, ram_req_o, ram_we_o,
          ram_be_o, ram_addr_o, ram_wdata_o, uart_psel_o, timer_psel_o, penable_o,
          pwrite_o, paddr_o, pwdata_o, pstrb_o}, 1'b0);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // RAM read
    run_req(1'b0, 4'hF, 32'h0000_0100, 32'h0, 3, 32'h1234_5678, 1'b0, 2);
    check("ram_rd_req_c0", obs_ram[0], 1'b0);
    check("ram_rd_req_c1", obs_ram[1], 1'b1);
    check("ram_rd_req_c2", obs_ram[2], 1'b0);
    check("ram_rd_addr", ram_addr_o, 32'h0000_0100);
    check("ram_rd_no_psel", obs_up[1] | obs_tp[1], 1'b0);

    // UART write, zero wait states
    run_req(1'b1, 4'h1, 32'h8000_0004, 32'h0000_00A5, 3, 32'h0, 1'b0, 2);
    check("uart_wr_psel_c1", obs_up[1], 1'b1);
    check("uart_wr_psel_c2", obs_up[2], 1'b1);
    check("uart_wr_psel_c3", obs_up[3], 1'b0);
    check("uart_wr_pen_c1", obs_pen[1], 1'b0);
    check("uart_wr_pen_c2", obs_pen[2], 1'b1);
    check("uart_wr_timer_psel", obs_tp[1] | obs_tp[2] | obs_tp[3], 1'b0);
    check("uart_wr_pwdata", pwdata_o, 32'h0000_00A5);
    check("uart_wr_pwrite", pwrite_o, 1'b1);
    check("uart_wr_pstrb", pstrb_o, 4'h1);

    // Timer read, four wait states
    run_req(1'b0, 4'hF, 32'h8000_1008, 32'h0, 7, 32'h0000_00FF, 1'b0, 6);
    for (int i = 1; i <= 6; i++) begin
      check("tmr_paddr_stable", obs_paddr[i], 32'h8000_1008);
      check("tmr_psel", obs_tp[i], 1'b1);
    end
    check("tmr_pen_c1", obs_pen[1], 1'b0);
    check("tmr_pen_c6", obs_pen[6], 1'b1);
    check("tmr_uart_psel", obs_up[2] | obs_up[6], 1'b0);

    // UART read that times out (APB_TIMEOUT=8)
    run_req(1'b0, 4'hF, 32'h8000_0010, 32'h0, 10, 32'hDEAD_BEEF, 1'b1, 1000);
    check("tmo_pen_c9", obs_pen[9], 1'b1);
    check("tmo_psel_c9", obs_up[9], 1'b1);

    // Back-to-back: RAM write then UART read accepted in the following IDLE
    run_req(1'b1, 4'h3, 32'h0000_0300, 32'h0000_0055, 3, 32'h0, 1'b0, 2);
    check("b2b_ram_we", ram_we_o, 1'b1);
    check("b2b_ram_be", ram_be_o, 4'h3);
    check("b2b_ram_wdata", ram_wdata_o, 32'h0000_0055);
    check("b2b_ram_addr", ram_addr_o, 32'h0000_0300);
    run_req(1'b0, 4'hF, 32'h8000_0008, 32'h0, 3, 32'h0BAD_0BAD, 1'b0, 2);
    check("b2b_uart_req_c0_ram", obs_ram[0], 1'b0);

    // Reset during APB ACCESS
    repeat (2) @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b0; core_be_i = 4'hF;
    core_addr_i = 32'h8000_0020; core_wdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    check("rst_pre_psel", uart_psel_o, 1'b1);
    check("rst_pre_pen", penable_o, 1'b1);
    #2 arstn_i = 1'b0;
    #1;
    check("rst_async_psel", uart_psel_o, 1'b0);
    check("rst_async_pen", penable_o, 1'b0);
    core_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("post_reset_outputs_zero", |{core_rvalid_o, core_rdata_o, bus_err_o, ram_req_o,
          ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o, uart_psel_o, timer_psel_o,
          penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o}, 1'b0);

    check("scoreboard_drained", sb.size(), 0);
    check("no_select_overlap", overlap, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
